// File: rtl/isa_types.sv
// Shared ISA-level types for the data-memory path.
//   - funct3 width codes for loads and stores
//   - lsu_state_t: load/store unit FSM states
//   - lsu_width_t: decoded access width
//   - decode_width / is_misaligned helpers
package isa_types;

    // Load funct3 codes
    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    // Store funct3 codes
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_ACCESS = 2'd1,
        LSU_DONE   = 2'd2,
        LSU_FAULT  = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        WID_BYTE = 2'd0,
        WID_HALF = 2'd1,
        WID_WORD = 2'd2,
        WID_INV  = 2'd3
    } lsu_width_t;

    // Signed and unsigned loads share a width; extension happens in execute.
    function automatic lsu_width_t decode_width(input logic is_store, input logic [2:0] f3);
        lsu_width_t w;
        w = WID_INV;
        if (is_store) begin
            case (f3)
                FUNCT3_SB: w = WID_BYTE;
                FUNCT3_SH: w = WID_HALF;
                FUNCT3_SW: w = WID_WORD;
                default:   w = WID_INV;
            endcase
        end else begin
            case (f3)
                FUNCT3_LB, FUNCT3_LBU: w = WID_BYTE;
                FUNCT3_LH, FUNCT3_LHU: w = WID_HALF;
                FUNCT3_LW:             w = WID_WORD;
                default:               w = WID_INV;
            endcase
        end
        return w;
    endfunction

    // An invalid width is reported through the same fault path as misalignment.
    function automatic logic is_misaligned(input lsu_width_t w, input logic [1:0] off);
        logic m;
        case (w)
            WID_HALF: m = off[0];
            WID_WORD: m = (off != 2'b00);
            WID_INV:  m = 1'b1;
            default:  m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering between a right-justified operand and a 32-bit word bus.
// Ports:
//   off_i        byte offset within the word (addr[1:0])
//   width_i      decoded access width
//   store_val_i  right-justified store data
//   rdata_i      raw word read from memory
//   be_o         byte enables for the access
//   wdata_o      store data shifted into its lanes
//   rdata_o      read data shifted down and masked to the access width
module lsu_lane_align
    import isa_types::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      off_i,
    input  lsu_width_t      width_i,
    input  logic [XLEN-1:0] store_val_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [3:0]      be_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [XLEN-1:0] rdata_o
);

    logic [XLEN-1:0] mask;
    logic [4:0]      shamt;

    assign shamt = {off_i, 3'b000};

    always_comb begin
        be_o = 4'b0000;
        mask = '0;
        case (width_i)
            WID_BYTE: begin
                be_o = 4'b0001 << off_i;
                mask = {{(XLEN-8){1'b0}}, 8'hFF};
            end
            WID_HALF: begin
                be_o = 4'b0011 << off_i;
                mask = {{(XLEN-16){1'b0}}, 16'hFFFF};
            end
            WID_WORD: begin
                be_o = 4'hF;
                mask = '1;
            end
            default: begin
                be_o = 4'b0000;
                mask = '0;
            end
        endcase
    end

    // Store data is shifted unmasked; lanes outside be_o are don't-care to memory.
    assign wdata_o = store_val_i << shamt;
    assign rdata_o = (rdata_i >> shamt) & mask;

endmodule

// File: rtl/load_store_unit.sv
// Sequential data-memory front end: one load or store per transaction,
// word-wide req/ack memory port with byte enables, right-justified load data.
// Optional macro LSU_TIMEOUT_EN: fault an access that sees no mem_ack within
// MAX_WAIT cycles (an ack on the final cycle still completes normally).
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   req_valid/req_is_store/req_funct3/req_addr/req_store_val   request in
//   busy, done, fault, load_val  status and result to execute
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata                   memory request
//   mem_ack, mem_rdata           memory response
module load_store_unit
    import isa_types::*;
#(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    input  logic            req_is_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_store_val,
    output logic            busy,
    output logic            done,
    output logic            fault,
    output logic [XLEN-1:0] load_val,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata
);

    if (XLEN != 32 || MAX_WAIT < 1) begin : g_param_check
        $error("load_store_unit: XLEN must be 32 and MAX_WAIT >= 1");
    end

    lsu_state_t      state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    lsu_width_t      width_q, width_d;
    logic            store_q, store_d;
    logic [XLEN-1:0] sval_q, sval_d;
    logic [XLEN-1:0] load_val_q, load_val_d;

    lsu_width_t      req_width;
    logic            req_misaligned;
    logic            in_access;
    logic            wait_expired;
    logic [3:0]      lane_be;
    logic [XLEN-1:0] lane_wdata;
    logic [XLEN-1:0] lane_rdata;

    assign req_width      = decode_width(req_is_store, req_funct3);
    assign req_misaligned = is_misaligned(req_width, req_addr[1:0]);
    assign in_access      = (state_q == LSU_ACCESS);

    lsu_lane_align #(.XLEN(XLEN)) u_align (
        .off_i       (addr_q[1:0]),
        .width_i     (width_q),
        .store_val_i (sval_q),
        .rdata_i     (mem_rdata),
        .be_o        (lane_be),
        .wdata_o     (lane_wdata),
        .rdata_o     (lane_rdata)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    logic [WAIT_W-1:0] wait_q, wait_d;

    // Outside ACCESS the counter sits at zero, so it is clear on every entry.
    always_comb begin
        wait_d = '0;
        if (in_access && !mem_ack) wait_d = wait_q + WAIT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) wait_q <= '0;
        else       wait_q <= wait_d;
    end

    // Expires on the MAX_WAIT-th ACCESS cycle; mem_ack is checked first.
    assign wait_expired = (wait_q == WAIT_W'(MAX_WAIT - 1));
`else
    assign wait_expired = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        width_d    = width_q;
        store_d    = store_q;
        sval_d     = sval_q;
        load_val_d = load_val_q;
        case (state_q)
            LSU_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    width_d = req_width;
                    store_d = req_is_store;
                    sval_d  = req_store_val;
                    state_d = req_misaligned ? LSU_FAULT : LSU_ACCESS;
                end
            end
            LSU_ACCESS: begin
                if (mem_ack) begin
                    if (!store_q) load_val_d = lane_rdata;
                    state_d = LSU_DONE;
                end else if (wait_expired) begin
                    state_d = LSU_FAULT;
                end
            end
            // Requests arriving here are dropped; they are re-sampled in IDLE.
            LSU_DONE:  state_d = LSU_IDLE;
            LSU_FAULT: state_d = LSU_IDLE;
            default:   state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= LSU_IDLE;
            addr_q     <= '0;
            width_q    <= WID_BYTE;
            store_q    <= 1'b0;
            sval_q     <= '0;
            load_val_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            width_q    <= width_d;
            store_q    <= store_d;
            sval_q     <= sval_d;
            load_val_q <= load_val_d;
        end
    end

    // Memory-side outputs are gated so the bus is quiet outside ACCESS.
    assign busy      = (state_q != LSU_IDLE);
    assign done      = (state_q == LSU_DONE);
    assign fault     = (state_q == LSU_FAULT);
    assign load_val  = load_val_q;
    assign mem_req   = in_access;
    assign mem_we    = in_access & store_q;
    assign mem_addr  = in_access ? {addr_q[XLEN-1:2], 2'b00} : '0;
    assign mem_be    = in_access ? lane_be : 4'b0000;
    assign mem_wdata = in_access ? lane_wdata : '0;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk, reset;
    logic        req_valid, req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_store_val;
    logic        busy, done, fault;
    logic [31:0] load_val;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        mem_ack;

    load_store_unit #(.XLEN(32), .MAX_WAIT(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_is_store  (req_is_store),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_store_val (req_store_val),
        .busy          (busy),
        .done          (done),
        .fault         (fault),
        .load_val      (load_val),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_be        (mem_be),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        flt;
        int          req_n;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        logic        chk_lv;
        logic [31:0] lval;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic flt, input int rn, input logic [31:0] a,
                                input logic [3:0] be, input logic [31:0] wd, input logic we,
                                input logic cl, input logic [31:0] lv);
        exp_t e;
        e.flt = flt; e.req_n = rn; e.addr = a; e.be = be; e.wdata = wd;
        e.we = we; e.chk_lv = cl; e.lval = lv;
        return e;
    endfunction

    // Monitor: records the memory request, checks it stays stable, and pops
    // the scoreboard on each done/fault pulse.
    int          req_n = 0;
    logic [31:0] o_addr, o_wdata;
    logic [3:0]  o_be;
    logic        o_we;

    always @(negedge clk) begin
        if (reset) begin
            req_n = 0;
        end else begin
            if (mem_req) begin
                if (req_n == 0) begin
                    o_addr = mem_addr; o_be = mem_be; o_wdata = mem_wdata; o_we = mem_we;
                end else begin
                    chk("req_stable", 32'({mem_addr, mem_be, mem_wdata, mem_we} ==
                                          {o_addr, o_be, o_wdata, o_we}), 32'd1);
                end
                chk("busy_acc", 32'(busy), 32'd1);
                req_n++;
            end
            if (done || fault) begin
                chk("sb_size", 32'(sb_q.size()), 32'd1);
                if (sb_q.size() > 0) begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("fault", 32'(fault), 32'(e.flt));
                    chk("busy_end", 32'(busy), 32'd1);
                    chk("req_cycles", 32'(req_n), 32'(e.req_n));
                    if (e.req_n > 0) begin
                        chk("mem_addr", o_addr, e.addr);
                        chk("mem_be", 32'(o_be), 32'(e.be));
                        chk("mem_wdata", o_wdata, e.wdata);
                        chk("mem_we", 32'(o_we), 32'(e.we));
                    end
                    if (e.chk_lv) chk("load_val", load_val, e.lval);
                end
                req_n = 0;
            end
        end
    end

    // dly >= 0: ack after dly further ACCESS cycles; dly < 0: never ack.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sv, input logic [31:0] rd, input int dly,
                         input exp_t e);
        sb_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
        req_addr = a; req_store_val = sv;
        @(negedge clk);
        req_valid = 1'b0;
        chk("busy_rise", 32'(busy), 32'd1);
        if (dly >= 0) begin
            repeat (dly) @(negedge clk);
            mem_ack = 1'b1; mem_rdata = rd;
            @(negedge clk);
            mem_ack = 1'b0; mem_rdata = '0;
            chk("done_lat", 32'(done), 32'd1);
        end else begin
            for (int i = 0; i < 40 && !(fault || done); i++) @(negedge clk);
            chk("end_pulse", 32'(fault), 32'(e.flt));
        end
        @(negedge clk);
        chk("busy_fall", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = '0;
        req_addr = '0; req_store_val = '0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_be", 32'(mem_be), 32'd0);
        chk("rst_lval", load_val, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        reset = 1'b0;

        // SW 0x104, ack two cycles after mem_req rises
        issue(1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 2,
              mk(1'b0, 3, 32'h104, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0));
        // SB 0x203
        issue(1'b1, 3'b000, 32'h203, 32'h000000A5, 32'h0, 0,
              mk(1'b0, 1, 32'h200, 4'b1000, 32'hA5000000, 1'b1, 1'b0, 32'h0));
        // LH 0x302
        issue(1'b0, 3'b001, 32'h302, 32'h0, 32'h8F7A1234, 1,
              mk(1'b0, 2, 32'h300, 4'b1100, 32'h0, 1'b0, 1'b1, 32'h00008F7A));
        // LW 0x101 misaligned: no memory access, load_val held
        issue(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, -1,
              mk(1'b1, 0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h00008F7A));
        // LB 0x007, top lane
        issue(1'b0, 3'b000, 32'h007, 32'h0, 32'h11223344, 0,
              mk(1'b0, 1, 32'h004, 4'b1000, 32'h0, 1'b0, 1'b1, 32'h00000011));
        // LHU odd address misaligned
        issue(1'b0, 3'b101, 32'h401, 32'h0, 32'h0, -1,
              mk(1'b1, 0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h00000011));
        // SH 0x002, upper half lanes
        issue(1'b1, 3'b001, 32'h002, 32'h1234ABCD, 32'h0, 1,
              mk(1'b0, 2, 32'h000, 4'b1100, 32'hABCD0000, 1'b1, 1'b0, 32'h0));
        // invalid funct3 for a store and for a load
        issue(1'b1, 3'b100, 32'h000, 32'h0, 32'h0, -1,
              mk(1'b1, 0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h00000011));
        issue(1'b0, 3'b011, 32'h000, 32'h0, 32'h0, -1,
              mk(1'b1, 0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h00000011));

        // mem_ack while idle is ignored
        @(negedge clk); mem_ack = 1'b1;
        @(negedge clk); mem_ack = 1'b0;
        chk("stray_ack_busy", 32'(busy), 32'd0);
        chk("stray_ack_done", 32'(done), 32'd0);
        chk("stray_ack_lval", load_val, 32'h00000011);

        // reset in the middle of an access
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h40; req_store_val = '0;
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        chk("mid_req", 32'(mem_req), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_req", 32'(mem_req), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_lval", load_val, 32'd0);
        reset = 1'b0;

        // LBU 0x10 after reset
        issue(1'b0, 3'b100, 32'h010, 32'h0, 32'h000000C3, 0,
              mk(1'b0, 1, 32'h010, 4'b0001, 32'h0, 1'b0, 1'b1, 32'h000000C3));

`ifdef LSU_TIMEOUT_EN
        // no ack: fault after four ACCESS cycles, load_val held
        issue(1'b0, 3'b010, 32'h020, 32'h0, 32'h0, -1,
              mk(1'b1, 4, 32'h020, 4'hF, 32'h0, 1'b0, 1'b1, 32'h000000C3));
`else
        // without the timeout a long wait still completes
        issue(1'b0, 3'b010, 32'h024, 32'h0, 32'h0BADF00D, 9,
              mk(1'b0, 10, 32'h024, 4'hF, 32'h0, 1'b0, 1'b1, 32'h0BADF00D));
`endif
        // ack on the fourth ACCESS cycle completes normally
        issue(1'b0, 3'b010, 32'h020, 32'h0, 32'hCAFEF00D, 3,
              mk(1'b0, 4, 32'h020, 4'hF, 32'h0, 1'b0, 1'b1, 32'hCAFEF00D));

        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
